// File: rtl/pc_alu_exec.sv
// ---------------------------------------------------------------------------
// pc_alu_exec
// Execution core of the 8-bit single-cycle CPU. It holds the 32-bit program
// counter with its PC+4 incrementer and branch-target adder, and the 8-bit
// ALU with its operand-B path. Operand B can be a register value, the two's
// complement of that register value, or an immediate. The ZERO flag is used
// inside this block to decide whether a branch is taken.
//
// Ports
//   CLK        in   1   clock; PC updates on the rising edge
//   RESET      in   1   synchronous, active-high; PC <= 0
//   STALL      in   1   memory busy-wait; holds PC
//   JUMP       in   1   unconditional PC-relative jump
//   BRANCH     in   1   branch when ZERO
//   OFFSET     in   8   signed word offset for jump/branch
//   OPERAND1   in   8   ALU operand A
//   OPERAND2   in   8   register operand B
//   IMMEDIATE  in   8   immediate operand
//   NEG_SEL    in   1   use two's complement of OPERAND2
//   IMM_SEL    in   1   use IMMEDIATE as operand B (overrides NEG_SEL)
//   ALUOP      in   3   000 fwd, 001 add, 010 and, 011 or, others give 0
//   PC         out  32  current program counter
//   PC_INC     out  32  PC + 4
//   ALURESULT  out  8   ALU result (also the data-memory address)
//   ZERO       out  1   ALURESULT == 0
//
// Build option
//   PC_ALU_UNIT_DELAY_EN  when defined, adds the lab timing-model delays
//                         (negation #1, fwd/and/or #1, add #2, PC_INC #1,
//                         target #2, PC register #1 after the edge). These
//                         delays are for simulation only. Leave the macro
//                         undefined for synthesis. Results are the same
//                         either way.
// ---------------------------------------------------------------------------
module pc_alu_exec (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        JUMP,
   input  logic        BRANCH,
   input  logic [7:0]  OFFSET,
   input  logic [7:0]  OPERAND1,
   input  logic [7:0]  OPERAND2,
   input  logic [7:0]  IMMEDIATE,
   input  logic        NEG_SEL,
   input  logic        IMM_SEL,
   input  logic [2:0]  ALUOP,
   output logic [31:0] PC,
   output logic [31:0] PC_INC,
   output logic [7:0]  ALURESULT,
   output logic        ZERO
);

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;

   logic [7:0]  neg_operand;
   logic [7:0]  operand_b;
   logic [7:0]  fwd_result;
   logic [7:0]  add_result;
   logic [7:0]  and_result;
   logic [7:0]  or_result;
   logic [31:0] offset_bytes;
   logic [31:0] target;
   logic        take_target;
   logic [31:0] next_pc;

   // The word offset is sign-extended and then scaled to bytes (x4).
   assign offset_bytes = {{22{OFFSET[7]}}, OFFSET, 2'b00};

`ifdef PC_ALU_UNIT_DELAY_EN
   assign #1 neg_operand = ~OPERAND2 + 8'd1;
   assign #1 fwd_result  = operand_b;
   assign #2 add_result  = OPERAND1 + operand_b;
   assign #1 and_result  = OPERAND1 & operand_b;
   assign #1 or_result   = OPERAND1 | operand_b;
   assign #1 PC_INC      = PC + 32'd4;
   assign #2 target      = PC_INC + offset_bytes;
`else
   // 8'h80 negates to itself and 8'h00 negates to 8'h00, as two's
   // complement does.
   assign neg_operand = ~OPERAND2 + 8'd1;
   assign fwd_result  = operand_b;
   assign add_result  = OPERAND1 + operand_b;
   assign and_result  = OPERAND1 & operand_b;
   assign or_result   = OPERAND1 | operand_b;
   assign PC_INC      = PC + 32'd4;
   assign target      = PC_INC + offset_bytes;
`endif

   // The immediate has priority over negation. Subtraction is ADD with
   // NEG_SEL set.
   always_comb begin
      operand_b = OPERAND2;
      if (IMM_SEL)
         operand_b = IMMEDIATE;
      else if (NEG_SEL)
         operand_b = neg_operand;
   end

   always_comb begin
      ALURESULT = 8'h00;
      case (ALUOP)
         OP_FWD:  ALURESULT = fwd_result;
         OP_ADD:  ALURESULT = add_result;
         OP_AND:  ALURESULT = and_result;
         OP_OR:   ALURESULT = or_result;
         default: ALURESULT = 8'h00;
      endcase
   end

   assign ZERO = (ALURESULT == 8'h00);

   // When JUMP is high the target is taken whatever ZERO says.
   assign take_target = JUMP | (BRANCH & ZERO);
   assign next_pc     = take_target ? target : PC_INC;

   // RESET has priority over STALL, and STALL has priority over the PC update.
   always_ff @(posedge CLK) begin
`ifdef PC_ALU_UNIT_DELAY_EN
      if (RESET)
         PC <= #1 32'd0;
      else if (!STALL)
         PC <= #1 next_pc;
`else
      if (RESET)
         PC <= 32'd0;
      else if (!STALL)
         PC <= next_pc;
`endif
   end

endmodule

// File: tb/tb_pc_alu_exec.sv
module tb_pc_alu_exec;

   logic        CLK = 1'b0;
   logic        RESET, STALL, JUMP, BRANCH, NEG_SEL, IMM_SEL;
   logic [7:0]  OFFSET, OPERAND1, OPERAND2, IMMEDIATE;
   logic [2:0]  ALUOP;
   logic [31:0] PC, PC_INC;
   logic [7:0]  ALURESULT;
   logic        ZERO;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] m_pc = 32'd0;

   pc_alu_exec dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .JUMP(JUMP), .BRANCH(BRANCH),
      .OFFSET(OFFSET), .OPERAND1(OPERAND1), .OPERAND2(OPERAND2),
      .IMMEDIATE(IMMEDIATE), .NEG_SEL(NEG_SEL), .IMM_SEL(IMM_SEL),
      .ALUOP(ALUOP), .PC(PC), .PC_INC(PC_INC), .ALURESULT(ALURESULT),
      .ZERO(ZERO)
   );

   always #5 CLK = ~CLK;

   // Reference ALU written with plain integer arithmetic.
   function automatic int ref_alu(int a, int r, int imm, bit neg, bit isel, int op);
      int b;
      if (isel)     b = imm;
      else if (neg) b = (256 - r) % 256;
      else          b = r;
      case (op)
         0: return b;
         1: return (a + b) % 256;
         2: return a & b;
         3: return a | b;
         default: return 0;
      endcase
   endfunction

   // Reference PC update for one clock edge, computed from the current inputs.
   function automatic logic [31:0] ref_pc_after_edge(logic [31:0] pc);
      longint t;
      int res;
      if (RESET) return 32'd0;
      if (STALL) return pc;
      res = ref_alu(OPERAND1, OPERAND2, IMMEDIATE, NEG_SEL, IMM_SEL, ALUOP);
      if (JUMP || (BRANCH && res == 0)) begin
         t = longint'(pc) + 4 + longint'($signed(OFFSET)) * 4;
         return t[31:0];
      end
      t = longint'(pc) + 4;
      return t[31:0];
   endfunction

   task automatic idle();
      RESET = 0; STALL = 0; JUMP = 0; BRANCH = 0; NEG_SEL = 0; IMM_SEL = 0;
      OFFSET = 0; OPERAND1 = 0; OPERAND2 = 0; IMMEDIATE = 0; ALUOP = 3'b000;
   endtask

   // Advances one rising edge and updates the model; #3 allows for the optional PC delay.
   task automatic tick();
      m_pc = ref_pc_after_edge(m_pc);
      @(posedge CLK);
      #3;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic test_reset();
      idle();
      RESET = 1;
      tick();
      tests_run++;
      if (PC !== 32'd0) begin
         tests_failed++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'd0);
      end
      tests_run++;
      if (PC_INC !== 32'd4) begin
         tests_failed++; $display("FAIL reset_pc_inc got=%h exp=%h", PC_INC, 32'd4);
      end
      RESET = 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         tests_run++;
         if (PC !== 32'(4 * i)) begin
            tests_failed++; $display("FAIL reset_count%0d got=%h exp=%h", i, PC, 32'(4 * i));
         end
      end
   endtask

   task automatic test_alu();
      logic [2:0] ops [5]    = '{3'b001, 3'b001, 3'b010, 3'b011, 3'b000};
      bit         negs [5]   = '{0, 1, 0, 0, 0};
      logic [7:0] expv [5]   = '{8'h08, 8'h02, 8'h01, 8'h07, 8'h03};
      idle();
      OPERAND1 = 8'h05; OPERAND2 = 8'h03;
      for (int i = 0; i < 5; i++) begin
         ALUOP = ops[i]; NEG_SEL = negs[i];
         settle();
         tests_run++;
         if (ALURESULT !== expv[i]) begin
            tests_failed++; $display("FAIL alu_case%0d got=%h exp=%h", i, ALURESULT, expv[i]);
         end
      end
      IMM_SEL = 1; IMMEDIATE = 8'hA5; ALUOP = 3'b000;
      for (int n = 0; n < 2; n++) begin
         NEG_SEL = n[0];
         settle();
         tests_run++;
         if (ALURESULT !== 8'hA5) begin
            tests_failed++; $display("FAIL alu_imm_neg%0d got=%h exp=%h", n, ALURESULT, 8'hA5);
         end
      end
      IMM_SEL = 0; NEG_SEL = 0; ALUOP = 3'b101;
      settle();
      tests_run++;
      if (ALURESULT !== 8'h00 || ZERO !== 1'b1) begin
         tests_failed++; $display("FAIL alu_reserved got=%h/%b exp=00/1", ALURESULT, ZERO);
      end
   endtask

   task automatic test_wrap_sign();
      idle();
      OPERAND1 = 8'hFF; OPERAND2 = 8'h01; ALUOP = 3'b001;
      settle();
      tests_run++;
      if (ALURESULT !== 8'h00 || ZERO !== 1'b1) begin
         tests_failed++; $display("FAIL add_wrap got=%h/%b exp=00/1", ALURESULT, ZERO);
      end
      OPERAND2 = 8'h80; NEG_SEL = 1; ALUOP = 3'b000;
      settle();
      tests_run++;
      if (ALURESULT !== 8'h80) begin
         tests_failed++; $display("FAIL neg_80 got=%h exp=%h", ALURESULT, 8'h80);
      end
      OPERAND2 = 8'h00;
      settle();
      tests_run++;
      if (ALURESULT !== 8'h00 || ZERO !== 1'b1) begin
         tests_failed++; $display("FAIL neg_00 got=%h/%b exp=00/1", ALURESULT, ZERO);
      end
   endtask

   task automatic test_branch();
      idle();
      RESET = 1; tick(); RESET = 0;
      tick(); tick();
      OPERAND1 = 8'h07; OPERAND2 = 8'h07; NEG_SEL = 1; ALUOP = 3'b001;
      BRANCH = 1; OFFSET = 8'hFE;
      settle();
      tests_run++;
      if (ZERO !== 1'b1) begin
         tests_failed++; $display("FAIL beq_zero got=%b exp=1", ZERO);
      end
      tick();
      tests_run++;
      if (PC !== 32'd4) begin
         tests_failed++; $display("FAIL beq_taken got=%h exp=%h", PC, 32'd4);
      end
      BRANCH = 0; tick();
      BRANCH = 1; OPERAND2 = 8'h06;
      tick();
      tests_run++;
      if (PC !== 32'd12) begin
         tests_failed++; $display("FAIL beq_not_taken got=%h exp=%h", PC, 32'd12);
      end
   endtask

   task automatic test_jump();
      idle();
      RESET = 1; tick(); RESET = 0;
      JUMP = 1; OFFSET = 8'h03; OPERAND1 = 8'h01; ALUOP = 3'b000; BRANCH = 1; OPERAND2 = 8'h09;
      tick();
      tests_run++;
      if (PC !== 32'd16) begin
         tests_failed++; $display("FAIL jump_fwd got=%h exp=%h", PC, 32'd16);
      end
      idle();
      RESET = 1; tick(); RESET = 0;
      JUMP = 1; OFFSET = 8'hFE;
      tick();
      tests_run++;
      if (PC !== 32'hFFFF_FFFC) begin
         tests_failed++; $display("FAIL jump_back got=%h exp=%h", PC, 32'hFFFF_FFFC);
      end
      JUMP = 0;
      settle();
      tests_run++;
      if (PC_INC !== 32'd0) begin
         tests_failed++; $display("FAIL pc_inc_wrap got=%h exp=%h", PC_INC, 32'd0);
      end
      tick();
      tests_run++;
      if (PC !== 32'd0) begin
         tests_failed++; $display("FAIL pc_wrap got=%h exp=%h", PC, 32'd0);
      end
   endtask

   task automatic test_stall();
      idle();
      RESET = 1; tick(); RESET = 0;
      JUMP = 1; OFFSET = 8'h04;
      tick();
      tests_run++;
      if (PC !== 32'd20) begin
         tests_failed++; $display("FAIL stall_setup got=%h exp=%h", PC, 32'd20);
      end
      STALL = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (PC !== 32'd20) begin
            tests_failed++; $display("FAIL stall_hold%0d got=%h exp=%h", i, PC, 32'd20);
         end
      end
      RESET = 1;
      tick();
      tests_run++;
      if (PC !== 32'd0) begin
         tests_failed++; $display("FAIL stall_reset got=%h exp=%h", PC, 32'd0);
      end
      RESET = 0; STALL = 0; JUMP = 0;
      tick();
      tests_run++;
      if (PC !== 32'd4) begin
         tests_failed++; $display("FAIL stall_release got=%h exp=%h", PC, 32'd4);
      end
   endtask

   task automatic test_random();
      int exp_alu;
      longint exp_inc;
      for (int i = 0; i < 300; i++) begin
         RESET     = ($urandom_range(0, 15) == 0);
         STALL     = ($urandom_range(0, 5) == 0);
         JUMP      = ($urandom_range(0, 5) == 0);
         BRANCH    = $urandom_range(0, 1);
         NEG_SEL   = $urandom_range(0, 1);
         IMM_SEL   = ($urandom_range(0, 3) == 0);
         ALUOP     = 3'($urandom_range(0, 7));
         OFFSET    = 8'($urandom);
         OPERAND1  = 8'($urandom);
         OPERAND2  = ($urandom_range(0, 2) == 0) ? OPERAND1 : 8'($urandom);
         IMMEDIATE = 8'($urandom);
         settle();
         exp_alu = ref_alu(OPERAND1, OPERAND2, IMMEDIATE, NEG_SEL, IMM_SEL, ALUOP);
         exp_inc = longint'(m_pc) + 4;
         tests_run++;
         if (ALURESULT !== 8'(exp_alu) || ZERO !== (exp_alu == 0) || PC_INC !== exp_inc[31:0]) begin
            tests_failed++;
            $display("FAIL rand_comb%0d got=%h/%b/%h exp=%h/%b/%h", i, ALURESULT, ZERO, PC_INC,
                     8'(exp_alu), (exp_alu == 0), exp_inc[31:0]);
         end
         tick();
         tests_run++;
         if (PC !== m_pc) begin
            tests_failed++; $display("FAIL rand_pc%0d got=%h exp=%h", i, PC, m_pc);
         end
      end
   endtask

   initial begin
      idle();
      RESET = 1;
      @(negedge CLK);
      test_reset();
      test_alu();
      test_wrap_sign();
      test_branch();
      test_jump();
      test_stall();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_alu_exec.md
# pc_alu_exec

Execution core of the 8-bit single-cycle CPU: holds the 32-bit program counter with its PC+4 incrementer and branch-target adder, and the 8-bit ALU with its two's-complement negation and immediate-select operand path. It sits between the register file/decoder (which supply operands and control) and the instruction/data memories (which consume PC and ALURESULT). The ZERO flag drives the branch decision internally.

## Interface
- No parameters; all widths fixed (PC 32 bits, data 8 bits).
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- STALL  in  1  memory busy-wait; holds PC when high.
- JUMP  in  1  unconditional PC-relative jump.
- BRANCH  in  1  branch if ZERO.
- OFFSET  in  8  signed word offset for jump/branch.
- OPERAND1  in  8  ALU operand A (register RT).
- OPERAND2  in  8  register operand B (register RS).
- IMMEDIATE  in  8  immediate operand.
- NEG_SEL  in  1  1 = use two's complement of OPERAND2.
- IMM_SEL  in  1  1 = use IMMEDIATE as operand B (overrides NEG_SEL).
- ALUOP  in  3  ALU function select.
- PC  out  32  current program counter.
- PC_INC  out  32  PC + 4.
- ALURESULT  out  8  ALU result (also data-memory address).
- ZERO  out  1  ALURESULT == 8'h00.

## Operation
- B = IMM_SEL ? IMMEDIATE : (NEG_SEL ? (~OPERAND2 + 1) mod 256 : OPERAND2). Negation of 8'h80 yields 8'h80; of 8'h00 yields 8'h00.
- ALUOP 000 FORWARD: ALURESULT = B. 001 ADD: (OPERAND1 + B) mod 256, carry discarded. 010 AND: OPERAND1 & B. 011 OR: OPERAND1 | B. 100–111 reserved: ALURESULT = 8'h00.
- ZERO = (ALURESULT == 0), combinational.
- PC_INC = PC + 4, wraps modulo 2^32.
- TARGET = PC_INC + (sign_extend32(OFFSET) << 2), modulo 2^32.
- Next PC: TARGET if JUMP, or if BRANCH and ZERO; otherwise PC_INC.
- Subtraction (sub, beq) = ADD with NEG_SEL=1; beq taken when OPERAND1 == OPERAND2.

## Timing
- Operand mux, ALU, ZERO, PC_INC, TARGET are purely combinational from inputs and current PC.
- PC register, rising edge of CLK, priority: RESET → PC = 0; else STALL → hold PC; else PC = next PC.
- Reset value: PC = 0, so PC_INC = 4 after reset; ALURESULT/ZERO follow inputs and are not reset.
- RESET with STALL high: reset wins. RESET mid-branch: reset wins, PC = 0.
- JUMP and BRANCH both high: jump taken regardless of ZERO.
- STALL released: next edge applies next PC computed from inputs current at that edge.
- Latency: one CLK edge from control/operand inputs to PC update.

## Configuration
- PC_ALU_UNIT_DELAY_EN: when defined, adds simulation delays matching the lab timing model: operand negation #1, FORWARD/AND/OR #1, ADD #2, PC_INC adder #1, TARGET adder #2, PC register update #1 after clock edge. When undefined, all paths are zero-delay and the block is fully synthesizable; functional results identical.

## Test plan
- Reset: RESET=1, one edge → PC=0, PC_INC=4; release, three edges with no control → PC=4, 8, 12.
- ALU: OPERAND1=8'h05, OPERAND2=8'h03: ADD→8'h08, ADD+NEG_SEL→8'h02, AND→8'h01, OR→8'h07, FORWARD→8'h03; IMM_SEL with IMMEDIATE=8'hA5 FORWARD→8'hA5 regardless of NEG_SEL; ALUOP=3'b101→8'h00, ZERO=1.
- Wrap/sign: OPERAND1=8'hFF ADD OPERAND2=8'h01 → 8'h00, ZERO=1; NEG_SEL with OPERAND2=8'h80 → B=8'h80.
- Branch: PC=8, OPERAND1=OPERAND2=8'h07, NEG_SEL, ADD, BRANCH, OFFSET=8'hFE → PC=8+4−8=4; with OPERAND2=8'h06 → PC=12.
- Jump: PC=0, JUMP, OFFSET=8'h03 → PC=16; PC=8'h...FFFFFFFC, no control → PC wraps to 0.
- Stall: STALL high for 3 edges at PC=20 → PC stays 20; RESET asserted while stalled → PC=0.
